// File: rtl/hex_seg_scan.sv
// Four-digit multiplexed 7-segment scanner with shadow/display
// double buffering, frame-aligned commit and leading-zero blanking.
module hex_seg_scan #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hex_val,
    input  logic [1:0] digit_sel,
    input  logic       load,
    input  logic       commit,
    input  logic [3:0] dp_in,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       pending,
    output logic       frame_done
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    shadow [4];
    logic [3:0]    disp   [4];

    logic          slot_end;
    logic          wrap;
    logic [31:0]   cnt32;
    logic          ghost;
    logic          lz_blank;
    logic          off;
    logic [3:0]    cur;

    function automatic logic [6:0] enc(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0: r = 7'h3F;
            4'h1: r = 7'h06;
            4'h2: r = 7'h5B;
            4'h3: r = 7'h4F;
            4'h4: r = 7'h66;
            4'h5: r = 7'h6D;
            4'h6: r = 7'h7D;
            4'h7: r = 7'h07;
            4'h8: r = 7'h7F;
            4'h9: r = 7'h6F;
            4'hA: r = 7'h77;
            4'hB: r = 7'h7C;
            4'hC: r = 7'h39;
            4'hD: r = 7'h5E;
            4'hE: r = 7'h79;
            default: r = 7'h71;
        endcase
        return r;
    endfunction

    assign slot_end = (cnt == CW'(REFRESH_DIV - 1));
    assign wrap     = slot_end && (idx == 2'd3);
    assign cnt32    = 32'(cnt);
    assign ghost    = cnt32 < 32'(BLANK_CYCLES);
    assign cur      = disp[idx];

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        lz_blank = 1'b0;
        if (blank_lz) begin
            case (idx)
                2'd3: lz_blank = (disp[3] == 4'h0);
                2'd2: lz_blank = (disp[3] == 4'h0) && (disp[2] == 4'h0);
                2'd1: lz_blank = (disp[3] == 4'h0) && (disp[2] == 4'h0)
                                 && (disp[1] == 4'h0);
                default: lz_blank = 1'b0;
            endcase
        end
    end

    assign off = ghost || lz_blank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= 2'd0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            an         <= 4'hF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= 4'h0;
                disp[i]   <= 4'h0;
            end
        end else begin
            cnt        <= slot_end ? '0 : cnt + CW'(1);
            idx        <= slot_end ? idx + 2'd1 : idx;
            frame_done <= wrap;

            // Transfer samples shadow before this edge's load lands.
            if (wrap && pending) begin
                for (int i = 0; i < 4; i++)
                    disp[i] <= shadow[i];
                pending <= commit;
            end else if (commit) begin
                pending <= 1'b1;
            end

            if (load)
                shadow[digit_sel] <= hex_val;

            if (off) begin
                an  <= 4'hF;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end else begin
                an  <= ~(4'b0001 << idx);
                seg <= ~enc(cur);
                dp  <= ~dp_in[idx];
            end
        end
    end

endmodule

// File: tb/tb_hex_seg_scan.sv
// Scoreboard bench for hex_seg_scan: a time-indexed reference model
// pushes expected outputs, a monitor pops and compares each cycle.
module tb_hex_seg_scan;

    localparam int DIV = 4;
    localparam int BLK = 1;
    localparam int FR  = 4 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] hex_val = 4'h0;
    logic [1:0] digit_sel = 2'd0;
    logic       load = 1'b0;
    logic       commit = 1'b0;
    logic [3:0] dp_in = 4'h0;
    logic       blank_lz = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       pending;
    logic       frame_done;

    hex_seg_scan #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
        .clk(clk), .rst(rst), .hex_val(hex_val), .digit_sel(digit_sel),
        .load(load), .commit(commit), .dp_in(dp_in), .blank_lz(blank_lz),
        .an(an), .seg(seg), .dp(dp), .pending(pending),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       pend;
        logic       fd;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   total = 0;
    int   bad = 0;

    int         mt;
    logic [3:0] m_sh [4];
    logic [3:0] m_disp [4];
    logic       m_pend;
    logic [6:0] enc_tab [16];
    logic [3:0] cur_dp = 4'h0;
    logic       cur_lz = 1'b0;

    logic [6:0] obs_seg [4];
    logic       obs_dp [4];
    logic       obs_lit [4];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, req,
                     $time);
        end
    endtask

    task automatic model_reset();
        mt = 0;
        m_pend = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_sh[i] = 4'h0;
            m_disp[i] = 4'h0;
        end
    endtask

    // Drive one cycle of inputs and predict the outputs after the next edge.
    task automatic drive(input logic ld, input logic [1:0] sel,
                         input logic [3:0] v, input logic cm);
        exp_t e;
        int   pos;
        int   dig;
        bit   wr;
        bit   off;
        bit   allz;
        load = ld;
        digit_sel = sel;
        hex_val = v;
        commit = cm;
        dp_in = cur_dp;
        blank_lz = cur_lz;
        pos = mt % DIV;
        dig = (mt / DIV) % 4;
        wr  = (mt % FR) == FR - 1;
        off = pos < BLK;
        if (cur_lz && dig > 0) begin
            allz = 1'b1;
            for (int k = dig; k < 4; k++)
                if (m_disp[k] != 4'h0) allz = 1'b0;
            if (allz) off = 1'b1;
        end
        e.an = 4'hF;
        e.seg = 7'h7F;
        e.dp = 1'b1;
        if (!off) begin
            e.an[dig] = 1'b0;
            e.seg = ~enc_tab[m_disp[dig]];
            e.dp = ~cur_dp[dig];
        end
        if (wr && m_pend) begin
            for (int i = 0; i < 4; i++) m_disp[i] = m_sh[i];
            m_pend = cm;
        end else if (cm) begin
            m_pend = 1'b1;
        end
        e.pend = m_pend;
        e.fd = wr;
        if (ld) m_sh[sel] = v;
        q.push_back(e);
        mt++;
    endtask

    task automatic step(input logic ld, input logic [1:0] sel,
                        input logic [3:0] v, input logic cm);
        @(negedge clk);
        drive(ld, sel, v, cm);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 4'h0, 1'b0);
    endtask

    task automatic go_to(input int ph);
        while ((mt % FR) != ph) idle(1);
    endtask

    // Observe one whole frame of lit digits as the monitor records them.
    task automatic frame_obs();
        go_to(0);
        idle(1);
        for (int i = 0; i < 4; i++) begin
            obs_seg[i] = 7'h00;
            obs_dp[i] = 1'bx;
            obs_lit[i] = 1'b0;
        end
        idle(FR - 1);
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " an"}, an, 4'hF);
        chk({tag, " seg"}, seg, 7'h7F);
        chk({tag, " dp"}, dp, 1'b1);
        chk({tag, " pending"}, pending, 1'b0);
        chk({tag, " frame_done"}, frame_done, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        load = 1'b0;
        commit = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_held");
        rst = 1'b0;
        model_reset();
        drive(1'b0, 2'd0, 4'h0, 1'b0);
    endtask

    task automatic commit_value(input logic [3:0] d3, input logic [3:0] d2,
                                input logic [3:0] d1, input logic [3:0] d0);
        go_to(2);
        step(1'b1, 2'd3, d3, 1'b0);
        step(1'b1, 2'd2, d2, 1'b0);
        step(1'b1, 2'd1, d1, 1'b0);
        step(1'b1, 2'd0, d0, 1'b0);
        step(1'b0, 2'd0, 4'h0, 1'b1);
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst && q.size() > 0) begin
            me = q.pop_front();
            chk("an", an, me.an);
            chk("seg", seg, me.seg);
            chk("dp", dp, me.dp);
            chk("pending", pending, me.pend);
            chk("frame_done", frame_done, me.fd);
            for (int k = 0; k < 4; k++) begin
                if (an == ~(4'b0001 << k)) begin
                    obs_seg[k] = seg;
                    obs_dp[k] = dp;
                    obs_lit[k] = 1'b1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] tab [16];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        for (int i = 0; i < 16; i++) enc_tab[i] = tab[i];
        model_reset();

        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        drive(1'b0, 2'd0, 4'h0, 1'b0);

        frame_obs();
        for (int k = 0; k < 4; k++) chk("post_rst digit", obs_seg[k], 7'h40);

        commit_value(4'h1, 4'h2, 4'h3, 4'h4);
        frame_obs();
        chk("scan d0", obs_seg[0], 7'h19);
        chk("scan d1", obs_seg[1], 7'h30);
        chk("scan d2", obs_seg[2], 7'h24);
        chk("scan d3", obs_seg[3], 7'h79);

        cur_lz = 1'b1;
        commit_value(4'h0, 4'h0, 4'h5, 4'h0);
        frame_obs();
        chk("lz d3 lit", obs_lit[3], 1'b0);
        chk("lz d2 lit", obs_lit[2], 1'b0);
        chk("lz d1", obs_seg[1], 7'h12);
        chk("lz d0", obs_seg[0], 7'h40);
        cur_lz = 1'b0;
        frame_obs();
        chk("nolz d3", obs_seg[3], 7'h40);
        chk("nolz d2", obs_seg[2], 7'h40);

        cur_dp = 4'b0101;
        frame_obs();
        chk("dp0", obs_dp[0], 1'b0);
        chk("dp1", obs_dp[1], 1'b1);
        chk("dp2", obs_dp[2], 1'b0);
        chk("dp3", obs_dp[3], 1'b1);
        cur_dp = 4'h0;

        go_to(15);
        step(1'b0, 2'd0, 4'h0, 1'b1);
        go_to(15);
        step(1'b1, 2'd0, 4'hF, 1'b0);
        frame_obs();
        chk("excluded load", obs_seg[0], 7'h40);
        step(1'b0, 2'd0, 4'h0, 1'b1);
        frame_obs();
        chk("late load", obs_seg[0], 7'h0E);

        for (int v = 0; v < 16; v++) begin
            step(1'b1, 2'd0, 4'(v), 1'b0);
            step(1'b0, 2'd0, 4'h0, 1'b1);
            frame_obs();
            chk("sweep", obs_seg[0], {25'd0, ~enc_tab[v]});
        end

        commit_value(4'h9, 4'h8, 4'h7, 4'h6);
        idle(3);
        do_reset();
        frame_obs();
        for (int k = 0; k < 4; k++) chk("midrst digit", obs_seg[k], 7'h40);

        for (int i = 0; i < 500; i++) begin
            cur_dp = 4'($urandom_range(0, 15));
            cur_lz = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        idle(2);
        @(posedge clk);
        #2;
        chk("queue drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
